// File: rtl/milano_pkg.sv
// Shared types and constants for the writeback arbiter.
package milano_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_LSU = 2'd1,
    WB_SRC_MDU = 2'd2
  } wb_src_e;

  localparam int WB_NUM_REQ = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module wb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_gnt
);

  always_comb begin
    int j;
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt[j]  = 1'b1;
        idx     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: per-source 1-entry buffers, round-robin grant,
// registered write port. MILANO_WB_ARB_PERF_EN enables the conflict cycle counter.
module wb_arbiter
  import milano_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic                       rf_we_o,
  output logic [ADDR_W-1:0]          rf_waddr_o,
  output logic [DATA_W-1:0]          rf_wdata_o,
  output logic [(1<<ADDR_W)-1:0]     wb_pending_o,
  output logic [31:0]                conflict_cnt_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_v;
  logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;

  wb_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (buf_v),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .idx     (win_idx),
    .any_gnt (any_gnt)
  );

  // Handshake: a write transfers on valid & ready. A buffer being drained this
  // cycle is ready again, so an uncontested source streams one write per cycle.
  assign req_ready_o = ~buf_v | gnt;

  // Writes to x0 are accepted and dropped so they never occupy a grant slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_v <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i] &&
            (req_addr_i[i*ADDR_W +: ADDR_W] != '0)) begin
          buf_v[i]    <= 1'b1;
          buf_addr[i] <= req_addr_i[i*ADDR_W +: ADDR_W];
          buf_data[i] <= req_data_i[i*DATA_W +: DATA_W];
        end else if (gnt[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= any_gnt;
      if (any_gnt) begin
        rf_waddr_o <= buf_addr[win_idx];
        rf_wdata_o <= buf_data[win_idx];
        rr_ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // The output register is excluded: the register file takes it at the next edge.
  always_comb begin
    wb_pending_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (buf_v[i]) wb_pending_o[buf_addr[i]] = 1'b1;
    end
  end

`ifdef MILANO_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt <= '0;
    end else if (($countones(buf_v) >= 2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`else
  assign conflict_cnt_o = 32'd0;
`endif

endmodule
